// File: rtl/order_engine.sv
// Order engine: turns (signal, allow, kill) beats into fixed-size buy/sell orders
// and tracks net position. Optional post-order dead time under QS_ORDER_COOLDOWN_EN.
module order_engine #(
  parameter logic signed [31:0] SIG_THRESH      = 32'sh0000_8000,
  parameter logic signed [31:0] ORDER_QTY       = 32'sh0001_0000,
  parameter logic signed [31:0] POS_LIMIT       = 32'sh000A_0000,
  parameter int                 COOLDOWN_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] signal_in,
  input  logic        allow_trade,
  input  logic        kill_switch,
  output logic        ord_valid,
  input  logic        ord_ready,
  output logic        ord_side,
  output logic [31:0] ord_qty,
  output logic [31:0] position_out,
  output logic        halted,
  input  logic        clear_halt
);

`ifdef QS_ORDER_COOLDOWN_EN
  typedef enum logic [1:0] {IDLE, ISSUE, COOLDOWN, HALT} state_t;
  localparam int CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
  logic [CW-1:0] cnt, cnt_n;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, HALT} state_t;
`endif

  state_t      state, state_n;
  logic        side_n;
  logic [31:0] qty_n, pos_n;
  logic        accept, buy_ok, sell_ok;

  // 33-bit sign-extended position arithmetic so limit checks never wrap
  logic signed [32:0] pos_x, qty_x, lim_x, buy_sum, sell_sum;
  assign pos_x    = {position_out[31], position_out};
  assign qty_x    = {ORDER_QTY[31], ORDER_QTY};
  assign lim_x    = {POS_LIMIT[31], POS_LIMIT};
  assign buy_sum  = pos_x + qty_x;
  assign sell_sum = pos_x - qty_x;

  assign in_ready = (state == IDLE) || (state == HALT);
  assign accept   = in_valid && in_ready;
  assign buy_ok   = ($signed(signal_in) > SIG_THRESH) && (buy_sum <= lim_x);
  assign sell_ok  = ($signed(signal_in) < -SIG_THRESH) && (sell_sum >= -lim_x);

  always_comb begin
    state_n = state;
    side_n  = ord_side;
    qty_n   = ord_qty;
    pos_n   = position_out;
`ifdef QS_ORDER_COOLDOWN_EN
    cnt_n   = cnt;
`endif
    case (state)
      IDLE: if (accept) begin
        if (kill_switch)       state_n = HALT;
        else if (!allow_trade) state_n = IDLE;
        else if (buy_ok)  begin state_n = ISSUE; side_n = 1'b1; qty_n = ORDER_QTY; end
        else if (sell_ok) begin state_n = ISSUE; side_n = 1'b0; qty_n = ORDER_QTY; end
      end
      ISSUE: if (ord_ready) begin
        pos_n = ord_side ? buy_sum[31:0] : sell_sum[31:0];
        qty_n = '0;
`ifdef QS_ORDER_COOLDOWN_EN
        if (COOLDOWN_CYCLES == 0) state_n = IDLE;
        else begin
          state_n = COOLDOWN;
          cnt_n   = CW'(COOLDOWN_CYCLES);
        end
`else
        state_n = IDLE;
`endif
      end
`ifdef QS_ORDER_COOLDOWN_EN
      COOLDOWN: begin
        cnt_n = cnt - 1'b1;
        if (cnt <= CW'(1)) state_n = IDLE;
      end
`endif
      HALT: if (clear_halt) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Outputs are registered copies of the next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ord_valid    <= 1'b0;
      ord_side     <= 1'b0;
      ord_qty      <= '0;
      position_out <= '0;
      halted       <= 1'b0;
`ifdef QS_ORDER_COOLDOWN_EN
      cnt          <= '0;
`endif
    end else begin
      ord_valid    <= (state_n == ISSUE);
      ord_side     <= side_n;
      ord_qty      <= qty_n;
      position_out <= pos_n;
      halted       <= (state_n == HALT);
`ifdef QS_ORDER_COOLDOWN_EN
      cnt          <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_order_engine.sv
// Directed bench for order_engine: reset, buy/sell, threshold, backpressure,
// position limit, kill/halt and reset mid-order.
module tb_order_engine;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] signal_in;
  logic        allow_trade, kill_switch;
  logic        ord_valid, ord_ready, ord_side;
  logic [31:0] ord_qty, position_out;
  logic        halted, clear_halt;

  int n_assert = 0;
  int n_fail   = 0;

  order_engine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .signal_in(signal_in), .allow_trade(allow_trade), .kill_switch(kill_switch),
    .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_side(ord_side),
    .ord_qty(ord_qty), .position_out(position_out), .halted(halted),
    .clear_halt(clear_halt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present one beat once the engine is ready; outputs are sampled just after the accept edge
  task automatic send(input logic [31:0] sig, input logic allow, input logic kill);
    int waited = 0;
    while (!in_ready && waited < 40) begin tick(); waited++; end
    if (waited >= 40) check("send_timeout", {31'b0, in_ready}, 32'd1);
    signal_in = sig; allow_trade = allow; kill_switch = kill; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; signal_in = '0; allow_trade = 1'b0;
    kill_switch = 1'b0; ord_ready = 1'b1; clear_halt = 1'b0;
    repeat (3) tick();
    // T1 reset
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_ord_valid", {31'b0, ord_valid}, 32'd0);
    check("rst_side",      {31'b0, ord_side},  32'd0);
    check("rst_qty",       ord_qty,            32'h0);
    check("rst_pos",       position_out,       32'h0);
    check("rst_halted",    {31'b0, halted},    32'd0);
    rst_n = 1'b1;
    tick();

    // T2 buy
    send(32'h0001_0000, 1'b1, 1'b0);
    check("buy_valid",    {31'b0, ord_valid}, 32'd1);
    check("buy_side",     {31'b0, ord_side},  32'd1);
    check("buy_qty",      ord_qty,            32'h0001_0000);
    check("buy_in_ready", {31'b0, in_ready},  32'd0);
    check("buy_pos_pre",  position_out,       32'h0);
    tick();
    check("buy_valid_drop", {31'b0, ord_valid}, 32'd0);
    check("buy_pos",        position_out,       32'h0001_0000);

    // T3 threshold boundaries, allow gating, then a sell
    send(32'h0000_8000, 1'b1, 1'b0);
    check("thr_pos_no_order", {31'b0, ord_valid}, 32'd0);
    send(32'hFFFF_8000, 1'b1, 1'b0);
    check("thr_neg_no_order", {31'b0, ord_valid}, 32'd0);
    send(32'h0005_0000, 1'b0, 1'b0);
    check("allow0_no_order",  {31'b0, ord_valid}, 32'd0);
    check("thr_pos_hold",     position_out,       32'h0001_0000);
    send(32'hFFFF_0000, 1'b1, 1'b0);
    check("sell_valid", {31'b0, ord_valid}, 32'd1);
    check("sell_side",  {31'b0, ord_side},  32'd0);
    tick();
    check("sell_pos", position_out, 32'h0);

    // T4 backpressure
    ord_ready = 1'b0;
    send(32'h0002_0000, 1'b1, 1'b0);
    in_valid = 1'b1; signal_in = 32'hFFFF_0000;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",    {31'b0, ord_valid}, 32'd1);
      check("bp_side",     {31'b0, ord_side},  32'd1);
      check("bp_qty",      ord_qty,            32'h0001_0000);
      check("bp_in_ready", {31'b0, in_ready},  32'd0);
      check("bp_pos",      position_out,       32'h0);
      tick();
    end
    in_valid = 1'b0;
    ord_ready = 1'b1;
    tick();
    check("bp_release_valid", {31'b0, ord_valid}, 32'd0);
    check("bp_release_pos",   position_out,       32'h0001_0000);

    // T5 position limit
    for (int i = 0; i < 9; i++) begin
      send(32'h0001_0000, 1'b1, 1'b0);
      tick();
    end
    check("lim_pos_full", position_out, 32'h000A_0000);
    send(32'h0001_0000, 1'b1, 1'b0);
    check("lim_no_order", {31'b0, ord_valid}, 32'd0);
    check("lim_pos_hold", position_out,       32'h000A_0000);
    send(32'hFFFF_0000, 1'b1, 1'b0);
    check("lim_sell_valid", {31'b0, ord_valid}, 32'd1);
    tick();
    check("lim_sell_pos", position_out, 32'h0009_0000);

    // T6 kill / halt / clear
    send(32'h0002_0000, 1'b1, 1'b1);
    check("kill_no_order", {31'b0, ord_valid}, 32'd0);
    check("kill_halted",   {31'b0, halted},    32'd1);
    check("halt_in_ready", {31'b0, in_ready},  32'd1);
    send(32'h0002_0000, 1'b1, 1'b0);
    check("halt_discard",  {31'b0, ord_valid}, 32'd0);
    check("halt_still",    {31'b0, halted},    32'd1);
    check("halt_pos",      position_out,       32'h0009_0000);
    clear_halt = 1'b1; in_valid = 1'b1; signal_in = 32'h0002_0000; allow_trade = 1'b1; kill_switch = 1'b0;
    tick();
    clear_halt = 1'b0; in_valid = 1'b0;
    check("clear_halted",   {31'b0, halted},    32'd0);
    check("clear_discard",  {31'b0, ord_valid}, 32'd0);
    check("clear_pos",      position_out,       32'h0009_0000);
    send(32'h0002_0000, 1'b1, 1'b0);
    check("post_halt_valid", {31'b0, ord_valid}, 32'd1);
    tick();
    check("post_halt_pos", position_out, 32'h000A_0000);
`ifdef QS_ORDER_COOLDOWN_EN
    for (int i = 0; i < 8; i++) begin
      check("cooldown_busy", {31'b0, in_ready}, 32'd0);
      tick();
    end
    check("cooldown_done", {31'b0, in_ready}, 32'd1);
`else
    check("no_cooldown_ready", {31'b0, in_ready}, 32'd1);
`endif

    // Reset mid-order drops the order and zeroes position
    ord_ready = 1'b0;
    send(32'hFFFF_0000, 1'b1, 1'b0);
    check("mid_valid", {31'b0, ord_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, ord_valid}, 32'd0);
    check("mid_rst_pos",   position_out,       32'h0);
    tick();
    rst_n = 1'b1;
    ord_ready = 1'b1;
    tick();
    check("mid_rst_ready", {31'b0, in_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
